// File: rtl/led_chaser.sv
// led_chaser: parametrised LED pattern generator (rotate left/right, bounce,
// blink-all) stepped by an internal prescaler tick.
// Optional build macro: LED_CHASER_SPEED_SEL_EN adds a speed[1:0] input that
// stretches the step period to CLK_DIV<<speed clk cycles.
module led_chaser #(
  parameter int unsigned N_LEDS     = 4,
  parameter int unsigned CLK_DIV    = 10000000,
  parameter bit          ACTIVE_LOW = 1'b1,
  localparam int unsigned POS_W     = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
`ifdef LED_CHASER_SPEED_SEL_EN
  input  logic [1:0]        speed,
`endif
  output logic [N_LEDS-1:0] led,
  output logic [POS_W-1:0]  pos,
  output logic              step
);

  typedef enum logic [1:0] {
    MODE_LEFT   = 2'b00,
    MODE_RIGHT  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [31:0]       CNT_MAX  = 32'(CLK_DIV - 1);
  localparam logic [POS_W-1:0]  POS_LAST = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0]  POS_ONE  = POS_W'(1);
  localparam logic [N_LEDS-1:0] PAT_RST  = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] LED_RST  = ACTIVE_LOW ? ~PAT_RST : PAT_RST;

  logic [31:0]       cnt_q, cnt_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  dir_e              dir_q, dir_d;
  logic              phase_q, phase_d;
  logic              step_q, step_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic [N_LEDS-1:0] pat;
  logic              base_tick;
  logic              tick;
  mode_e             mode_s;

  assign mode_s = mode_e'(mode);

  // Base prescaler: counts enabled cycles, fires base_tick on wrap.
  always_comb begin
    cnt_d     = cnt_q;
    base_tick = 1'b0;
    if (en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d     = '0;
        base_tick = 1'b1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

`ifdef LED_CHASER_SPEED_SEL_EN
  logic [2:0] post_q, post_d;
  logic [1:0] speed_q, speed_d;
  logic [2:0] post_lim;
  logic [2:0] post_cur;

  // Post-divider: counts base ticks up to 2^speed; a speed change seen at a
  // base tick restarts the count from zero under the new setting.
  always_comb begin
    post_d   = post_q;
    speed_d  = speed_q;
    post_cur = post_q;
    tick     = 1'b0;
    case (speed)
      2'd0:    post_lim = 3'd0;
      2'd1:    post_lim = 3'd1;
      2'd2:    post_lim = 3'd3;
      default: post_lim = 3'd7;
    endcase
    if (base_tick) begin
      speed_d  = speed;
      post_cur = (speed != speed_q) ? 3'd0 : post_q;
      if (post_cur == post_lim) begin
        post_d = '0;
        tick   = 1'b1;
      end else begin
        post_d = post_cur + 3'd1;
      end
    end
  end

  // Post-divider registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      post_q  <= '0;
      speed_q <= '0;
    end else begin
      post_q  <= post_d;
      speed_q <= speed_d;
    end
  end
`else
  assign tick = base_tick;
`endif

  // Pattern next state: mode is only consulted on tick cycles.
  always_comb begin
    pos_d   = pos_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    led_d   = led_q;
    step_d  = tick;
    pat     = '0;
    if (tick) begin
      dir_d   = DIR_UP;
      phase_d = 1'b0;
      case (mode_s)
        MODE_LEFT: begin
          pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_ONE;
        end
        MODE_RIGHT: begin
          pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_ONE;
        end
        MODE_BOUNCE: begin
          if (N_LEDS == 1) begin
            pos_d = '0;
          end else if (dir_q == DIR_UP) begin
            if (pos_q == POS_LAST) begin
              dir_d = DIR_DOWN;
              pos_d = POS_LAST - POS_ONE;
            end else begin
              dir_d = DIR_UP;
              pos_d = pos_q + POS_ONE;
            end
          end else begin
            if (pos_q == '0) begin
              dir_d = DIR_UP;
              pos_d = POS_ONE;
            end else begin
              dir_d = DIR_DOWN;
              pos_d = pos_q - POS_ONE;
            end
          end
        end
        default: begin
          phase_d = ~phase_q;
        end
      endcase
      if (mode_s == MODE_BLINK) begin
        pat = {N_LEDS{phase_d}};
      end else begin
        for (int unsigned i = 0; i < N_LEDS; i++) begin
          pat[i] = (pos_d == POS_W'(i));
        end
      end
      led_d = ACTIVE_LOW ? ~pat : pat;
    end
  end

  // State registers; reset returns to one-hot bit 0, moving up.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      pos_q   <= '0;
      dir_q   <= DIR_UP;
      phase_q <= 1'b0;
      step_q  <= 1'b0;
      led_q   <= LED_RST;
    end else begin
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      led_q   <= led_d;
    end
  end

  assign led  = led_q;
  assign pos  = pos_q;
  assign step = step_q;

endmodule
